cla_seq_adder: RTL and testbench

//  Parametrised multi-cycle carry-lookahead adder/subtractor with optional accumulator.

---
 rtl/cla_pkg.sv | 19 +
 rtl/cla_slice.sv | 50 +++++
 rtl/cla_seq_adder.sv | 177 +++++++++++++++++
 tb/tb_cla_seq_adder.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// Shared definitions for the sequential carry-lookahead adder.
//   state_t : FSM encoding (IDLE -> RUN -> DONE -> IDLE)
//   nslice  : number of SLICE-bit steps needed to cover WIDTH bits
package cla_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // A degenerate slice width returns 1 so that a bad parameter reaches the
  // elaboration check in the top instead of dividing by zero here.
  function automatic int nslice(input int width, input int slice);
    if (slice < 1) return 1;
    return width / slice;
  endfunction

endpackage

// File: rtl/cla_slice.sv
// Combinational SLICE-bit carry-lookahead adder slice.
// Ports:
//   a, b  : slice operands
//   cin   : carry into bit 0
//   s     : slice sum
//   cout  : carry out of the top bit
//   c_msb : carry into the top bit (used for two's-complement overflow)
module cla_slice #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] s,
  output logic             cout,
  output logic             c_msb
);

  logic [SLICE-1:0] g;
  logic [SLICE-1:0] p;
  logic [SLICE:0]   c;

  assign g = a & b;
  assign p = a ^ b;

  // Every carry is a flat sum of products of g/p/cin, so no carry depends on
  // the carry below it: c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]cin.
  always_comb begin
    logic term;
    logic carry;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < SLICE; i++) begin
      term = cin;
      for (int j = 0; j <= i; j++) term = term & p[j];
      carry = term;
      for (int j = 0; j <= i; j++) begin
        term = g[j];
        for (int k = j + 1; k <= i; k++) term = term & p[k];
        carry = carry | term;
      end
      c[i+1] = carry;
    end
  end

  assign s     = p ^ c[SLICE-1:0];
  assign cout  = c[SLICE];
  assign c_msb = c[SLICE-1];

endmodule

// File: rtl/cla_seq_adder.sv
// Multi-cycle carry-lookahead adder/subtractor with optional accumulator.
// One SLICE-bit slice is added per clock; the slice carry is registered
// between cycles. The result is held until the consumer takes it.
//
// Handshake: a transfer happens on a rising clock edge where both valid and
// ready are high. in_ready is high only in IDLE; out_valid is high only in
// DONE. Neither depends combinationally on the opposite-side input.
//
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operand handshake
//   a, b, cin, sub      : operands; sub=1 computes a + ~b + 1 (cin ignored)
//   acc_mode            : accumulator replaces a; result written back to it
//   acc_clr             : clear accumulator (IDLE only; wins over same-cycle accept)
//   out_valid/out_ready : result handshake
//   sum, cout, ovf, zero: result and flags, valid while out_valid=1
//   state               : current FSM state (debug)
module cla_seq_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  input  logic             acc_mode,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output state_t           state
);

  localparam int NSLICE = nslice(WIDTH, SLICE);
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  if ((SLICE < 1) || (SLICE > WIDTH) || ((WIDTH % SLICE) != 0)) begin : g_bad_param
    $error("cla_seq_adder: WIDTH must be a positive multiple of SLICE");
  end

  state_t            state_q;
  state_t            state_d;
  logic [IDXW-1:0]   idx_q;
  logic [WIDTH-1:0]  op_a_q;
  logic [WIDTH-1:0]  op_b_q;
  logic              carry_q;
  logic              acc_mode_q;
  logic [WIDTH-1:0]  acc_q;
  logic [WIDTH-1:0]  work_q;
  logic [WIDTH-1:0]  sum_q;
  logic              cout_q;
  logic              ovf_q;
  logic              zero_q;

  logic              accept;
  logic              last;
  logic [31:0]       base;
  logic [SLICE-1:0]  slice_a;
  logic [SLICE-1:0]  slice_b;
  logic [SLICE-1:0]  slice_s;
  logic              slice_cout;
  logic              slice_c_msb;
  logic [WIDTH-1:0]  sum_next;
  logic [WIDTH-1:0]  acc_eff;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (last) state_d = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign accept = (state_q == ST_IDLE) && in_valid;
  assign last   = (idx_q == IDXW'(NSLICE - 1));
  assign state  = state_q;

  // ---------------- slice datapath ----------------
  assign base    = 32'(idx_q) * 32'(SLICE);
  assign slice_a = op_a_q[base +: SLICE];
  assign slice_b = op_b_q[base +: SLICE];

  cla_slice #(.SLICE(SLICE)) u_slice (
    .a     (slice_a),
    .b     (slice_b),
    .cin   (carry_q),
    .s     (slice_s),
    .cout  (slice_cout),
    .c_msb (slice_c_msb)
  );

  // Lower slices are already in work_q when the last slice completes, so this
  // is the full result on the final RUN cycle.
  always_comb begin
    sum_next = work_q;
    sum_next[base +: SLICE] = slice_s;
  end

  // A clear in the accepting cycle takes effect before the operand is latched.
  assign acc_eff = acc_clr ? '0 : acc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q      <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      carry_q    <= 1'b0;
      acc_mode_q <= 1'b0;
      acc_q      <= '0;
      work_q     <= '0;
      sum_q      <= '0;
      cout_q     <= 1'b0;
      ovf_q      <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (acc_clr) acc_q <= '0;
          if (accept) begin
            op_a_q     <= acc_mode ? acc_eff : a;
            op_b_q     <= sub ? ~b : b;
            carry_q    <= sub ? 1'b1 : cin;
            acc_mode_q <= acc_mode;
            idx_q      <= '0;
          end
        end
        ST_RUN: begin
          work_q  <= sum_next;
          carry_q <= slice_cout;
          if (last) begin
            sum_q  <= sum_next;
            cout_q <= slice_cout;
            ovf_q  <= slice_cout ^ slice_c_msb;
            zero_q <= (sum_next == '0);
            if (acc_mode_q) acc_q <= sum_next;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;
  assign zero = zero_q;

endmodule

// File: tb/tb_cla_seq_adder.sv
module tb_cla_seq_adder;
  import cla_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic        cin = 1'b0, sub = 1'b0, acc_mode = 1'b0, acc_clr = 1'b0;

  // index 0: SLICE=4, 1: SLICE=1, 2: SLICE=16
  logic        in_ready_o [3];
  logic        out_valid_o[3];
  logic [15:0] sum_o      [3];
  logic        cout_o     [3];
  logic        ovf_o      [3];
  logic        zero_o     [3];
  state_t      state_o    [3];

  cla_seq_adder #(.WIDTH(16), .SLICE(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_o[0]),
    .a(a), .b(b), .cin(cin), .sub(sub), .acc_mode(acc_mode), .acc_clr(acc_clr),
    .out_valid(out_valid_o[0]), .out_ready(out_ready), .sum(sum_o[0]),
    .cout(cout_o[0]), .ovf(ovf_o[0]), .zero(zero_o[0]), .state(state_o[0]));

  cla_seq_adder #(.WIDTH(16), .SLICE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_o[1]),
    .a(a), .b(b), .cin(cin), .sub(sub), .acc_mode(acc_mode), .acc_clr(acc_clr),
    .out_valid(out_valid_o[1]), .out_ready(out_ready), .sum(sum_o[1]),
    .cout(cout_o[1]), .ovf(ovf_o[1]), .zero(zero_o[1]), .state(state_o[1]));

  cla_seq_adder #(.WIDTH(16), .SLICE(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_o[2]),
    .a(a), .b(b), .cin(cin), .sub(sub), .acc_mode(acc_mode), .acc_clr(acc_clr),
    .out_valid(out_valid_o[2]), .out_ready(out_ready), .sum(sum_o[2]),
    .cout(cout_o[2]), .ovf(ovf_o[2]), .zero(zero_o[2]), .state(state_o[2]));

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] mdl_acc = '0;
  logic [15:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [15:0] es,
                           input logic ec, input logic eo, input logic ez);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("%s.d%0d.sum", tag, d), 32'(sum_o[d]), 32'(es));
      chk($sformatf("%s.d%0d.cout", tag, d), 32'(cout_o[d]), 32'(ec));
      chk($sformatf("%s.d%0d.ovf", tag, d), 32'(ovf_o[d]), 32'(eo));
      chk($sformatf("%s.d%0d.zero", tag, d), 32'(zero_o[d]), 32'(ez));
    end
  endtask

  // Independent reference: full-width arithmetic, carry into MSB from the
  // 15-bit low sum.
  task automatic ref_calc(input logic [15:0] ra, input logic [15:0] rb, input logic rc,
                          input logic rs, output logic [15:0] s, output logic co,
                          output logic ov, output logic z);
    logic [16:0] full;
    logic [15:0] low;
    logic [15:0] opb;
    logic        c0;
    opb  = rs ? ~rb : rb;
    c0   = rs ? 1'b1 : rc;
    full = {1'b0, ra} + {1'b0, opb} + {16'b0, c0};
    low  = {1'b0, ra[14:0]} + {1'b0, opb[14:0]} + {15'b0, c0};
    s    = full[15:0];
    co   = full[16];
    ov   = low[15] ^ co;
    z    = (s == 16'h0000);
  endtask

  // ---------------- driver tasks ----------------
  // Presents one operand; returns just after the accepting edge with the
  // inputs scrambled so only latched copies can produce the right answer.
  task automatic send(input logic [15:0] va, input logic [15:0] vb, input logic vc,
                      input logic vs, input logic vm, input logic vclr);
    @(posedge clk); #1;
    a = va; b = vb; cin = vc; sub = vs; acc_mode = vm; acc_clr = vclr;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = ~va; b = ~vb; cin = ~vc; sub = ~vs; acc_mode = ~vm; acc_clr = 1'b0;
    // model side of the same transaction
    if (vclr) mdl_acc = '0;
  endtask

  task automatic wait_done(output int lat4);
    int cyc;
    cyc  = 0;
    lat4 = -1;
    while (!(out_valid_o[0] && out_valid_o[1] && out_valid_o[2]) && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (out_valid_o[0] && lat4 < 0) lat4 = cyc;
    end
    chk("done_in_time", 32'(out_valid_o[0] && out_valid_o[1] && out_valid_o[2]), 32'd1);
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("release.out_valid", 32'(out_valid_o[0] | out_valid_o[1] | out_valid_o[2]), 32'd0);
    chk("release.in_ready", 32'(in_ready_o[0] & in_ready_o[1] & in_ready_o[2]), 32'd1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [15:0] va;
    logic [15:0] vb;
    logic        vc;
    logic        vs;
    logic        vm;
    logic        vclr;
    logic [15:0] es;
    logic        ec;
    logic        eo;
    logic        ez;
  } vec_t;

  vec_t vecs[13];

  initial begin
    int lat;
    logic [15:0] es;
    logic        ec, eo, ez;
    logic [15:0] opa;
    logic [15:0] hold_s;

    //            a        b        cin  sub  accm clr   sum      cout ovf  zero
    vecs[0]  = '{16'h1234, 16'h0FCD, 1'b0, 1'b0, 1'b0, 1'b0, 16'h2201, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[3]  = '{16'h0005, 16'h0007, 1'b0, 1'b1, 1'b0, 1'b0, 16'hFFFE, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 1'b0, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{16'hFFFF, 16'h4000, 1'b0, 1'b0, 1'b1, 1'b1, 16'h4000, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{16'hFFFF, 16'h4000, 1'b0, 1'b0, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{16'hFFFF, 16'h4000, 1'b0, 1'b0, 1'b1, 1'b0, 16'hC000, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{16'h00FF, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{16'h0010, 16'h0010, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[10] = '{16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0002, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{16'hAAAA, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{16'h0000, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};

    // reset
    #23;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("reset.d%0d.state", d), 32'(state_o[d]), 32'(ST_IDLE));
      chk($sformatf("reset.d%0d.in_ready", d), 32'(in_ready_o[d]), 32'd1);
      chk($sformatf("reset.d%0d.out_valid", d), 32'(out_valid_o[d]), 32'd0);
    end
    check_all("reset", 16'h0000, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;

    // table-driven vectors
    for (int i = 0; i < 13; i++) begin
      send(vecs[i].va, vecs[i].vb, vecs[i].vc, vecs[i].vs, vecs[i].vm, vecs[i].vclr);
      chk($sformatf("v%0d.in_ready_run", i), 32'(in_ready_o[0]), 32'd0);
      chk($sformatf("v%0d.early_valid", i), 32'(out_valid_o[0]), 32'd0);
      wait_done(lat);
      chk($sformatf("v%0d.latency", i), 32'(lat), 32'd4);
      check_all($sformatf("v%0d", i), vecs[i].es, vecs[i].ec, vecs[i].eo, vecs[i].ez);
      if (vecs[i].vm) mdl_acc = vecs[i].es;
      release_out();
    end

    // backpressure, with in_valid and acc_clr asserted while in DONE
    send(16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_done(lat);
    check_all("bp.first", 16'h0003, 1'b0, 1'b0, 1'b0);
    hold_s = 16'h0003;
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      acc_clr  = 1'b1;
      a = 16'(k * 16'h1111);
      @(posedge clk); #1;
      chk($sformatf("bp.c%0d.sum", k), 32'(sum_o[0]), 32'(hold_s));
      chk($sformatf("bp.c%0d.out_valid", k), 32'(out_valid_o[0]), 32'd1);
      chk($sformatf("bp.c%0d.in_ready", k), 32'(in_ready_o[0]), 32'd0);
    end
    in_valid = 1'b0;
    acc_clr  = 1'b0;
    check_all("bp.hold", 16'h0003, 1'b0, 1'b0, 1'b0);
    release_out();

    // accumulator survived the ignored clear: 1 + 2 = 3
    send(16'h0000, 16'h0002, 1'b0, 1'b0, 1'b1, 1'b0);
    wait_done(lat);
    check_all("acc_after_bp", 16'h0003, 1'b0, 1'b0, 1'b0);
    mdl_acc = 16'h0003;
    release_out();

    // reset on the second RUN cycle
    send(16'h0000, 16'h0005, 1'b0, 1'b0, 1'b1, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("midrst.d%0d.state", d), 32'(state_o[d]), 32'(ST_IDLE));
      chk($sformatf("midrst.d%0d.in_ready", d), 32'(in_ready_o[d]), 32'd1);
      chk($sformatf("midrst.d%0d.out_valid", d), 32'(out_valid_o[d]), 32'd0);
    end
    mdl_acc = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    send(16'h0000, 16'h0007, 1'b0, 1'b0, 1'b1, 1'b0);
    wait_done(lat);
    check_all("after_rst_acc", 16'h0007, 1'b0, 1'b0, 1'b0);
    mdl_acc = 16'h0007;
    release_out();
    send(16'h1234, 16'h0FCD, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_done(lat);
    chk("after_rst.latency", 32'(lat), 32'd4);
    check_all("after_rst_add", 16'h2201, 1'b0, 1'b0, 1'b0);
    release_out();

    // random sweep across all three slice widths against the reference
    for (int i = 0; i < 24; i++) begin
      logic [15:0] ra, rb;
      logic rc, rs, rm, rclr;
      ra   = 16'($urandom_range(0, 16'hFFFF));
      rb   = 16'($urandom_range(0, 16'hFFFF));
      rc   = 1'($urandom_range(0, 1));
      rs   = 1'($urandom_range(0, 1));
      rm   = 1'($urandom_range(0, 1));
      rclr = ($urandom_range(0, 7) == 0);
      send(ra, rb, rc, rs, rm, rclr);
      opa = rm ? mdl_acc : ra;
      ref_calc(opa, rb, rc, rs, es, ec, eo, ez);
      if (rm) mdl_acc = es;
      exp_q.push_back(es);
      wait_done(lat);
      chk($sformatf("rnd%0d.latency", i), 32'(lat), 32'd4);
      check_all($sformatf("rnd%0d", i), exp_q.pop_front(), ec, eo, ez);
      release_out();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
